logic_async_sram_emu: RTL and testbench

LOGIC_ASYNC_SRAM_EMU -- requirements
Module: logic_async_sram_emu

---
 rtl/logic_async_sram_emu_if.sv | 14 +
 rtl/logic_async_sram_emu.sv | 162 ++++++++++++++++
 tb/tb_logic_async_sram_emu.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/logic_async_sram_emu_if.sv
// Pin-level bus of the asynchronous SRAM emulator (address, strobes, ready).
// The bidirectional data pins stay a plain inout port on the emulator.
interface logic_async_sram_emu_if #(
  parameter int unsigned AW = 15
) ();
  logic [AW-1:0] A;
  logic          nCS;
  logic          nOE;
  logic          nWE;
  logic          READY;

  modport master (output A, output nCS, output nOE, output nWE, input READY);
  modport slave  (input A, input nCS, input nOE, input nWE, output READY);
endinterface

// File: rtl/logic_async_sram_emu.sv
// Asynchronous SRAM emulator: synchronised pin strobes drive a 4-state FSM over a clocked RAM.
// Optional power-up clear of the whole array is enabled by defining SRAM_EMU_CLEAR_EN.
module logic_async_sram_emu #(
  parameter int unsigned AW          = 15,
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  logic_async_sram_emu_if.slave  bus,
  inout  wire  [DW-1:0]          IO
);

  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [1:0] {StInit, StIdle, StRead, StWrite} state_e;

`ifdef SRAM_EMU_CLEAR_EN
  localparam state_e ResetState = StInit;
`else
  localparam state_e ResetState = StIdle;
`endif

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_oe_sync;
  logic [SYNC_STAGES-1:0] r_we_sync;
  logic [AW-1:0]          r_a_pipe [SYNC_STAGES];
  logic [DW-1:0]          r_d_pipe [SYNC_STAGES];

  logic          w_scs;
  logic          w_soe;
  logic          w_swe;
  logic [AW-1:0] w_sa;
  logic [DW-1:0] w_sd;

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_wa;
  logic [DW-1:0] r_wd;
  logic          w_cap;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_waddr;
  logic [DW-1:0] w_ram_wdata;

  logic [DW-1:0] r_mem [Depth];
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_dout;
  logic          r_oe;
  logic          r_ready;
  logic          w_io_oe;

`ifdef SRAM_EMU_CLEAR_EN
  logic [AW-1:0] r_clr_cnt;
`endif

  // Address and data ride a pipeline as deep as the strobe synchronisers so they stay aligned.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cs_sync <= '1;
      r_oe_sync <= '1;
      r_we_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_a_pipe[i] <= '0;
        r_d_pipe[i] <= '0;
      end
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.nCS};
      r_oe_sync   <= {r_oe_sync[SYNC_STAGES-2:0], bus.nOE};
      r_we_sync   <= {r_we_sync[SYNC_STAGES-2:0], bus.nWE};
      r_a_pipe[0] <= bus.A;
      r_d_pipe[0] <= IO;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_a_pipe[i] <= r_a_pipe[i-1];
        r_d_pipe[i] <= r_d_pipe[i-1];
      end
    end
  end

  assign w_scs = r_cs_sync[SYNC_STAGES-1];
  assign w_soe = r_oe_sync[SYNC_STAGES-1];
  assign w_swe = r_we_sync[SYNC_STAGES-1];
  assign w_sa  = r_a_pipe[SYNC_STAGES-1];
  assign w_sd  = r_d_pipe[SYNC_STAGES-1];

  // Address/data are latched while the write is active; the commit uses the last latched pair.
  assign w_cap = (r_state != StInit) && !w_scs && !w_swe;

  always_comb begin
    w_state_next = r_state;
    w_ram_we     = 1'b0;
    w_ram_waddr  = r_wa;
    w_ram_wdata  = r_wd;
    unique case (r_state)
`ifdef SRAM_EMU_CLEAR_EN
      StInit: begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_clr_cnt;
        w_ram_wdata = '0;
        if (r_clr_cnt == {AW{1'b1}}) w_state_next = StIdle;
      end
`endif
      StIdle: begin
        if (!w_scs && !w_swe)      w_state_next = StWrite;
        else if (!w_scs && !w_soe) w_state_next = StRead;
      end
      StRead: begin
        if (w_scs)       w_state_next = StIdle;
        else if (!w_swe) w_state_next = StWrite;
        else if (w_soe)  w_state_next = StIdle;
      end
      StWrite: begin
        if (w_scs || w_swe) begin
          w_ram_we     = 1'b1;
          w_state_next = (!w_scs && !w_soe && w_swe) ? StRead : StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ResetState;
      r_wa    <= '0;
      r_wd    <= '0;
      r_oe    <= 1'b0;
      r_dout  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_cap) begin
        r_wa <= w_sa;
        r_wd <= w_sd;
      end
      r_oe    <= (r_state == StRead) && (w_state_next == StRead);
      r_dout  <= r_rdata;
      r_ready <= (r_state != StInit);
    end
  end

`ifdef SRAM_EMU_CLEAR_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_clr_cnt <= '0;
    end else if (r_state == StInit) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end
`endif

  // Write-first: a read of the address being committed returns the new data.
  always_ff @(posedge CLK) begin
    if (w_ram_we) r_mem[w_ram_waddr] <= w_ram_wdata;
    if (w_ram_we && (w_ram_waddr == w_sa)) r_rdata <= w_ram_wdata;
    else                                   r_rdata <= r_mem[w_sa];
  end

  assign w_io_oe   = r_oe && w_swe;
  assign IO        = w_io_oe ? r_dout : {DW{1'bz}};
  assign bus.READY = r_ready;

endmodule

// File: tb/tb_logic_async_sram_emu.sv
// Directed bench for logic_async_sram_emu; a pull-up on IO makes a released bus read as 8'hFF.
// Define SRAM_EMU_CLEAR_EN to run the AW=4 power-up clear sequence instead of the main sequence.
module tb_logic_async_sram_emu;

`ifdef SRAM_EMU_CLEAR_EN
  localparam int unsigned AW = 4;
`else
  localparam int unsigned AW = 15;
`endif
  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          tb_drv;
  logic [DW-1:0] tb_dat;
  wire  [DW-1:0] IO;
  int            checks = 0;
  int            errors = 0;
  int            wr_count = 0;
  int            c0;

  logic_async_sram_emu_if #(.AW(AW)) bus ();

  logic_async_sram_emu #(
    .AW          (AW),
    .DW          (DW),
    .SYNC_STAGES (2)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus),
    .IO   (IO)
  );

  assign IO = tb_drv ? tb_dat : {DW{1'bz}};
  pullup (IO);

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (dut.w_ram_we) wr_count <= wr_count + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_start(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.A   = a;
    tb_dat  = d;
    tb_drv  = 1'b1;
    bus.nCS = 1'b0;
    bus.nWE = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
    wr_start(a, d);
    repeat (n) tick();
    bus.nWE = 1'b1;
    bus.nCS = 1'b1;
    tb_drv  = 1'b0;
    repeat (4) tick();
  endtask

  // Data is expected exactly four edges after the address and nOE are applied.
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    bus.A   = a;
    bus.nCS = 1'b0;
    bus.nOE = 1'b0;
    repeat (3) tick();
    check({tag, "_hiz"}, IO, 8'hFF);
    tick();
    check(tag, IO, exp);
    bus.nOE = 1'b1;
    bus.nCS = 1'b1;
    repeat (3) tick();
    check({tag, "_rel"}, IO, 8'hFF);
  endtask

  initial begin
    nRST    = 1'b0;
    bus.A   = '0;
    bus.nCS = 1'b1;
    bus.nOE = 1'b1;
    bus.nWE = 1'b1;
    tb_drv  = 1'b0;
    tb_dat  = '0;
    repeat (3) tick();
    check("rst_ready", bus.READY, 1'b0);
    check("rst_io", IO, 8'hFF);
    nRST = 1'b1;

`ifdef SRAM_EMU_CLEAR_EN
    wr_start(3, 8'h77);
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 3) begin
        bus.nWE = 1'b1;
        bus.nCS = 1'b1;
        tb_drv  = 1'b0;
      end
      check("clr_ready", bus.READY, (i == 17) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 16; i++) rd(AW'(i), 8'h00, "clr_rd");
`else
    tick();
    check("ready_up", bus.READY, 1'b1);

    // Long write followed by read-back.
    c0 = wr_count;
    wr(15'h1234, 8'hA5, 6);
    check("one_write", wr_count - c0, 1);
    rd(15'h1234, 8'hA5, "rd_1234");

    // nCS rises before nWE; data presented after the nCS rise must not be stored.
    c0 = wr_count;
    wr_start(15'h0001, 8'h3C);
    repeat (4) tick();
    bus.nCS = 1'b1;
    tb_dat  = 8'h99;
    tick();
    bus.nWE = 1'b1;
    tb_drv  = 1'b0;
    repeat (4) tick();
    check("cs_first_one_write", wr_count - c0, 1);
    rd(15'h0001, 8'h3C, "rd_0001");

    // nOE and nWE low together: bus must not be driven by the emulator.
    c0 = wr_count;
    bus.nOE = 1'b0;
    wr_start(15'h0100, 8'h42);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ovl_io", IO, 8'h42);
    end
    bus.nWE = 1'b1;
    tb_drv  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovl_post_hiz", IO, 8'hFF);
    end
    tick();
    check("ovl_bypass", IO, 8'h42);
    bus.nOE = 1'b1;
    bus.nCS = 1'b1;
    repeat (3) tick();
    check("ovl_rel", IO, 8'hFF);
    check("ovl_one_write", wr_count - c0, 1);

    // Back-to-back writes at both ends of the address range.
    c0 = wr_count;
    wr_start(15'h7FFF, 8'h5A);
    repeat (3) tick();
    bus.nWE = 1'b1;
    bus.A   = 15'h0000;
    tb_dat  = 8'hC3;
    tick();
    bus.nWE = 1'b0;
    repeat (3) tick();
    bus.nWE = 1'b1;
    bus.nCS = 1'b1;
    tb_drv  = 1'b0;
    repeat (4) tick();
    check("b2b_writes", wr_count - c0, 2);
    rd(15'h7FFF, 8'h5A, "rd_7fff");
    rd(15'h0000, 8'hC3, "rd_0000");

    // Reset during a read, then during a write.
    wr(15'h7FFF, 8'h11, 3);
    rd(15'h7FFF, 8'h11, "rd_11");
    bus.A   = 15'h7FFF;
    bus.nCS = 1'b0;
    bus.nOE = 1'b0;
    repeat (4) tick();
    check("pre_rst_rd", IO, 8'h11);
    nRST = 1'b0;
    #1;
    check("rst_rd_io", IO, 8'hFF);
    check("rst_rd_ready", bus.READY, 1'b0);
    bus.nOE = 1'b1;
    bus.nCS = 1'b1;
    tick();
    nRST = 1'b1;
    tick();
    c0 = wr_count;
    wr_start(15'h7FFF, 8'hFF);
    repeat (4) tick();
    nRST   = 1'b0;
    tb_drv = 1'b0;
    #1;
    check("rst_wr_io", IO, 8'hFF);
    bus.nWE = 1'b1;
    bus.nCS = 1'b1;
    repeat (2) tick();
    nRST = 1'b1;
    repeat (4) tick();
    check("rst_wr_discard", wr_count - c0, 0);
    check("rst_wr_ready", bus.READY, 1'b1);
    rd(15'h7FFF, 8'h11, "rd_after_rst");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
